// File: rtl/prog_loader_arbiter.sv
// prog_loader_arbiter
// Shares the program RAM between the CPU control sequencer and an external
// byte-stream loader. In RUN the control word passes straight through; in
// LOAD the CPU is held in reset while this block drives the bus and the
// MAR/MDR/RAM write strobes for each streamed byte.
// Optional build macro: LOADER_CHECKSUM_EN (running modulo-256 byte sum).
//
// state | meaning
// ------+---------------------------------------------------------------
// RUN   | CPU owns the datapath, ctrl_out follows cpu_ctrl
// HOLD  | CPU held in reset, load address cleared
// WAIT  | ready for a loader byte, exit evaluated here
// ADDR  | bus carries load address, MAR load strobe
// DATA  | bus carries captured byte, MDR load strobe
// WRITE | RAM write strobe, address advances
// DONE  | one-cycle completion pulse, CPU released on the next cycle
module prog_loader_arbiter #(
  parameter int ADDR_W    = 4,
  parameter int RAM_BYTES = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_req,
  input  logic              wr_valid,
  input  logic [7:0]        wr_data,
  output logic              wr_ready,
  input  logic [14:0]       cpu_ctrl,
  output logic [14:0]       ctrl_out,
  output logic [7:0]        bus_out,
  output logic              bus_oe,
  output logic              cpu_rst_n,
  output logic [ADDR_W-1:0] load_addr,
  output logic              load_done,
  output logic [7:0]        checksum
);

  // All active-low controls high, all active-high controls low.
  localparam logic [14:0] IDLE_WORD  = 15'h0FE3;
  localparam logic [14:0] MASK_NLMA  = 15'h0800;
  localparam logic [14:0] MASK_NLMD  = 15'h0400;
  localparam logic [14:0] MASK_NLR   = 15'h0100;
  localparam logic [14:0] CTRL_ADDR  = IDLE_WORD & ~MASK_NLMA;
  localparam logic [14:0] CTRL_DATA  = IDLE_WORD & ~MASK_NLMD;
  localparam logic [14:0] CTRL_WRITE = IDLE_WORD & ~MASK_NLR;

  typedef enum logic [2:0] {
    S_RUN,
    S_HOLD,
    S_WAIT,
    S_ADDR,
    S_DATA,
    S_WRITE,
    S_DONE
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [7:0]  byte_q;
  logic [14:0] ctrl_q;
  logic        last_addr;
  logic        xfer;

  assign last_addr = (load_addr == ADDR_W'(RAM_BYTES - 1));
  // wr_ready is only ever high in WAIT, so this is the WAIT-state handshake.
  assign xfer      = wr_valid && wr_ready;

  // In RUN the CPU word must reach the datapath in the same cycle.
  assign ctrl_out = (state == S_RUN) ? cpu_ctrl : ctrl_q;

  // Next-state decode; a byte accepted in WAIT always beats a falling request.
  always_comb begin
    state_nxt = state;
    case (state)
      S_RUN:   state_nxt = load_req ? S_HOLD : S_RUN;
      S_HOLD:  state_nxt = S_WAIT;
      S_WAIT: begin
        if (xfer)           state_nxt = S_ADDR;
        else if (!load_req) state_nxt = S_DONE;
        else                state_nxt = S_WAIT;
      end
      S_ADDR:  state_nxt = S_DATA;
      S_DATA:  state_nxt = S_WRITE;
      S_WRITE: state_nxt = last_addr ? S_DONE : S_WAIT;
      S_DONE:  state_nxt = S_RUN;
      default: state_nxt = S_RUN;
    endcase
  end

  // State register; every output is registered from the upcoming state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_RUN;
      load_addr <= '0;
      wr_ready  <= 1'b0;
      bus_oe    <= 1'b0;
      bus_out   <= 8'h00;
      load_done <= 1'b0;
      cpu_rst_n <= 1'b1;
      ctrl_q    <= IDLE_WORD;
      byte_q    <= 8'h00;
    end else begin
      state     <= state_nxt;
      wr_ready  <= (state_nxt == S_WAIT);
      load_done <= (state_nxt == S_DONE);
      cpu_rst_n <= (state_nxt == S_RUN);
      bus_oe    <= (state_nxt == S_ADDR) || (state_nxt == S_DATA);

      if (xfer) byte_q <= wr_data;

      if (state_nxt == S_HOLD)
        load_addr <= '0;
      else if (state == S_WRITE)
        load_addr <= last_addr ? '0 : load_addr + 1'b1;

      case (state_nxt)
        S_ADDR: begin
          bus_out <= 8'(load_addr);
          ctrl_q  <= CTRL_ADDR;
        end
        S_DATA: begin
          bus_out <= byte_q;
          ctrl_q  <= CTRL_DATA;
        end
        S_WRITE: begin
          bus_out <= 8'h00;
          ctrl_q  <= CTRL_WRITE;
        end
        default: begin
          bus_out <= 8'h00;
          ctrl_q  <= IDLE_WORD;
        end
      endcase
    end
  end

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] sum_q;

  // Running modulo-256 sum of bytes written since the last HOLD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      sum_q <= 8'h00;
    else if (state_nxt == S_HOLD)
      sum_q <= 8'h00;
    else if (state == S_WRITE)
      sum_q <= sum_q + byte_q;
  end

  assign checksum = sum_q;
`else
  assign checksum = 8'h00;
`endif

endmodule

// File: tb/tb_prog_loader_arbiter.sv
// Self-checking bench for prog_loader_arbiter. A small RAM/MAR/MDR model
// watches the bus and control word the way the real datapath would, and
// the expected RAM image, checksum and handshake schedule are derived from
// the bytes the bench chooses to stream.
module tb_prog_loader_arbiter;

  localparam logic [14:0] IDLE_W  = 15'h0FE3;
  localparam logic [14:0] ADDR_W_ = 15'h07E3;
  localparam logic [14:0] DATA_W  = 15'h0BE3;
  localparam logic [14:0] WRITE_W = 15'h0EE3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load_req;
  logic        wr_valid;
  logic [7:0]  wr_data;
  logic        wr_ready;
  logic [14:0] cpu_ctrl;
  logic [14:0] ctrl_out;
  logic [7:0]  bus_out;
  logic        bus_oe;
  logic        cpu_rst_n;
  logic [3:0]  load_addr;
  logic        load_done;
  logic [7:0]  checksum;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] load_bytes [16];
  logic [7:0] exp_ram [16] = '{default: 8'h00};

  // datapath-side observer
  logic [3:0] m_mar = 4'h0;
  logic [7:0] m_mdr = 8'h00;
  logic [7:0] m_ram [16] = '{default: 8'h00};
  int         m_writes = 0;
  int         done_pulses = 0;

  prog_loader_arbiter #(.ADDR_W(4), .RAM_BYTES(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_req  (load_req),
    .wr_valid  (wr_valid),
    .wr_data   (wr_data),
    .wr_ready  (wr_ready),
    .cpu_ctrl  (cpu_ctrl),
    .ctrl_out  (ctrl_out),
    .bus_out   (bus_out),
    .bus_oe    (bus_oe),
    .cpu_rst_n (cpu_rst_n),
    .load_addr (load_addr),
    .load_done (load_done),
    .checksum  (checksum)
  );

  always #5 clk = ~clk;

  // MAR/MDR/RAM react to the control word only while the loader owns the CPU
  always @(negedge clk) begin
    if (rst_n && !cpu_rst_n) begin
      if (bus_oe && !ctrl_out[11]) m_mar <= bus_out[3:0];
      if (bus_oe && !ctrl_out[10]) m_mdr <= bus_out;
      if (!ctrl_out[8]) begin
        m_ram[m_mar] <= m_mdr;
        m_writes     <= m_writes + 1;
      end
    end
    if (load_done) done_pulses <= done_pulses + 1;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] exp_sum(input logic [7:0] s);
`ifdef LOADER_CHECKSUM_EN
    return s;
`else
    return (s & 8'h00);
`endif
  endfunction

  // mode 0: drop load_req in the WAIT after the last byte
  // mode 1: drop load_req in the same cycle as the last byte transfer
  // mode 2: drop load_req somewhere inside the last byte's ADDR/DATA/WRITE
  task automatic do_load(input int n, input int mode, input bit gaps, input bit keep_req);
    logic [7:0] sum;
    int         pulses0;
    int         writes0;
    int         drop_k;
    sum     = 8'h00;
    pulses0 = done_pulses;
    writes0 = m_writes;
    drop_k  = $urandom_range(0, 2);
    load_req = 1'b1;
    wr_valid = 1'b0;
    cpu_ctrl = 15'($urandom);
    step();
    check_val("hold_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
    check_val("hold_ctrl_out",  32'(ctrl_out),  32'(IDLE_W));
    check_val("hold_wr_ready",  32'(wr_ready),  32'd0);
    step();
    for (int i = 0; i < n; i++) begin
      int gap;
      gap = gaps ? int'($urandom_range(0, 3)) : 0;
      for (int g = 0; g <= gap; g++) begin
        check_val("wait_wr_ready",  32'(wr_ready),  32'd1);
        check_val("wait_ctrl_out",  32'(ctrl_out),  32'(IDLE_W));
        check_val("wait_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
        check_val("wait_bus_oe",    32'(bus_oe),    32'd0);
        check_val("wait_load_addr", 32'(load_addr), 32'(i));
        cpu_ctrl = 15'($urandom);
        if (g < gap) begin
          wr_valid = 1'b0;
          wr_data  = 8'($urandom);
        end else begin
          wr_valid = 1'b1;
          wr_data  = load_bytes[i];
          if (mode == 1 && i == n - 1) load_req = 1'b0;
        end
        step();
      end
      for (int k = 0; k < 3; k++) begin
        check_val("busy_wr_ready",  32'(wr_ready),  32'd0);
        check_val("busy_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
        if (k == 0) begin
          check_val("addr_bus_oe",   32'(bus_oe),   32'd1);
          check_val("addr_bus_out",  32'(bus_out),  32'(i));
          check_val("addr_ctrl_out", 32'(ctrl_out), 32'(ADDR_W_));
        end else if (k == 1) begin
          check_val("data_bus_oe",   32'(bus_oe),   32'd1);
          check_val("data_bus_out",  32'(bus_out),  32'(load_bytes[i]));
          check_val("data_ctrl_out", 32'(ctrl_out), 32'(DATA_W));
        end else begin
          check_val("write_bus_oe",   32'(bus_oe),   32'd0);
          check_val("write_ctrl_out", 32'(ctrl_out), 32'(WRITE_W));
        end
        // junk offered while not ready must be ignored
        wr_valid = 1'($urandom);
        wr_data  = 8'($urandom);
        cpu_ctrl = 15'($urandom);
        if (mode == 2 && i == n - 1 && k == drop_k) load_req = 1'b0;
        step();
      end
      sum        = sum + load_bytes[i];
      exp_ram[i] = load_bytes[i];
    end
    if (n < 16) begin
      check_val("exit_wr_ready",  32'(wr_ready),  32'd1);
      check_val("exit_load_addr", 32'(load_addr), 32'(n));
      wr_valid = 1'b0;
      load_req = 1'b0;
      step();
    end
    check_val("done_pulse",     32'(load_done), 32'd1);
    check_val("done_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
    check_val("done_ctrl_out",  32'(ctrl_out),  32'(IDLE_W));
    check_val("done_load_addr", 32'(load_addr), (n == 16) ? 32'd0 : 32'(n));
    check_val("done_checksum",  32'(checksum),  32'(exp_sum(sum)));
    check_val("ram_writes",     32'(m_writes - writes0), 32'(n));
    for (int a = 0; a < 16; a++)
      check_val($sformatf("ram[%0d]", a), 32'(m_ram[a]), 32'(exp_ram[a]));
    wr_valid = 1'b0;
    load_req = keep_req;
    cpu_ctrl = 15'($urandom);
    step();
    check_val("run_cpu_rst_n",  32'(cpu_rst_n), 32'd1);
    check_val("run_load_done",  32'(load_done), 32'd0);
    check_val("run_ctrl_out",   32'(ctrl_out),  32'(cpu_ctrl));
    check_val("run_bus_oe",     32'(bus_oe),    32'd0);
    check_val("run_checksum",   32'(checksum),  32'(exp_sum(sum)));
    check_val("done_once",      32'(done_pulses - pulses0), 32'd1);
  endtask

  task automatic passthrough(input logic [14:0] v);
    cpu_ctrl = v;
    #1;
    check_val("pass_ctrl_out",  32'(ctrl_out),  32'(v));
    check_val("pass_bus_oe",    32'(bus_oe),    32'd0);
    check_val("pass_cpu_rst_n", 32'(cpu_rst_n), 32'd1);
  endtask

  initial begin
    int writes0;
    rst_n    = 1'b0;
    load_req = 1'b1;
    wr_valid = 1'b0;
    wr_data  = 8'h00;
    cpu_ctrl = 15'h1234;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_ctrl_out",  32'(ctrl_out),  32'h1234);
    check_val("rst_wr_ready",  32'(wr_ready),  32'd0);
    check_val("rst_cpu_rst_n", 32'(cpu_rst_n), 32'd1);
    check_val("rst_load_addr", 32'(load_addr), 32'd0);
    check_val("rst_bus_oe",    32'(bus_oe),    32'd0);
    check_val("rst_bus_out",   32'(bus_out),   32'd0);
    check_val("rst_load_done", 32'(load_done), 32'd0);
    check_val("rst_checksum",  32'(checksum),  32'd0);
    load_req = 1'b0;
    rst_n    = 1'b1;
    step();

    passthrough(15'h5A5A);
    for (int k = 0; k < 3; k++) passthrough(15'($urandom));

    // full load 0x10..0x1F back to back, request held so a new load follows
    for (int i = 0; i < 16; i++) load_bytes[i] = 8'(8'h10 + i);
    do_load(16, 0, 1'b0, 1'b1);
`ifdef LOADER_CHECKSUM_EN
    check_val("full_checksum", 32'(checksum), 32'h78);
`endif

    // early exit after three bytes; request reasserted in DONE
    load_bytes[0] = 8'hAA;
    load_bytes[1] = 8'hBB;
    load_bytes[2] = 8'hCC;
    do_load(3, 0, 1'b0, 1'b1);

    // transfer and falling request in the same WAIT cycle
    for (int i = 0; i < 16; i++) load_bytes[i] = 8'($urandom);
    do_load(2, 1, 1'b1, 1'b0);
    passthrough(15'($urandom));

    for (int r = 0; r < 6; r++) begin
      int n;
      int mode;
      n    = $urandom_range(1, 16);
      mode = $urandom_range(0, 2);
      for (int i = 0; i < 16; i++) load_bytes[i] = 8'($urandom);
      do_load(n, mode, 1'b1, 1'b0);
      passthrough(15'($urandom));
    end

    // asynchronous reset while the loader is in DATA
    writes0  = m_writes;
    load_req = 1'b1;
    step();
    step();
    wr_valid = 1'b1;
    wr_data  = 8'h5C;
    step();
    wr_valid = 1'b0;
    step();
    check_val("arst_pre_bus_oe", 32'(bus_oe), 32'd1);
    load_req = 1'b0;
    cpu_ctrl = 15'h2D3C;
    #1 rst_n = 1'b0;
    #1;
    check_val("arst_bus_oe",    32'(bus_oe),    32'd0);
    check_val("arst_cpu_rst_n", 32'(cpu_rst_n), 32'd1);
    check_val("arst_wr_ready",  32'(wr_ready),  32'd0);
    check_val("arst_ctrl_out",  32'(ctrl_out),  32'h2D3C);
    check_val("arst_load_addr", 32'(load_addr), 32'd0);
    check_val("arst_checksum",  32'(checksum),  32'd0);
    #1 rst_n = 1'b1;
    step();
    check_val("arst_no_write", 32'(m_writes - writes0), 32'd0);

    for (int i = 0; i < 16; i++) load_bytes[i] = 8'($urandom);
    do_load(4, 2, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/prog_loader_arbiter.md
Name: prog_loader_arbiter

Overview:
- Shares the 16-byte program RAM between the CPU control sequencer and an external byte-stream program loader.
- In RUN it passes the control-block word straight to the datapath.
- In LOAD it holds the CPU in reset, drives the shared 8-bit bus itself, and sequences the MAR/RAM control lines to write streamed bytes to consecutive addresses.
- Sits between the control block output and all datapath control inputs.

Parameters:
- ADDR_W, 4, RAM address width.
- RAM_BYTES, 16, number of bytes loaded before auto-completion; must equal 2**ADDR_W.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- load_req  input  1  level request to enter or stay in load mode.
- wr_valid  input  1  loader byte valid.
- wr_data  input  8  loader byte.
- wr_ready  output  1  block accepts a byte this cycle.
- cpu_ctrl  input  15  control word from control block, bit order {Cp,Ep,Lp,nLma,nLmd,nCE,nLr,nLi,nEi,nLa,Ea,sub,Eu,nLb,nLo}.
- ctrl_out  output  15  control word to the datapath, same bit order.
- bus_out  output  8  value driven onto the shared bus.
- bus_oe  output  1  bus_out is valid (tri-state enable).
- cpu_rst_n  output  1  active-low reset to PC, control block and IR.
- load_addr  output  ADDR_W  next RAM address to be written.
- load_done  output  1  one-cycle pulse when load completes.
- checksum  output  8  see Optional Feature.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low (rst_n).
- IDLE word = 15'h0FE3 (all active-low controls high, all active-high controls low).
- Reset values:
  - state=RUN, load_addr=0, wr_ready=0, bus_oe=0, bus_out=0, load_done=0, cpu_rst_n=1, checksum=0.
  - ctrl_out follows cpu_ctrl combinationally in RUN.
- States: RUN, HOLD, WAIT, ADDR, DATA, WRITE, DONE.
- RUN:
  - ctrl_out=cpu_ctrl, bus_oe=0.
  - load_req=1 → HOLD.
- HOLD (1 cycle):
  - ctrl_out=IDLE, cpu_rst_n=0, load_addr cleared to 0.
  - → WAIT.
- WAIT:
  - wr_ready=1, ctrl_out=IDLE, cpu_rst_n=0.
  - Transfer when wr_valid & wr_ready: capture wr_data into an internal byte register → ADDR.
  - If no transfer and load_req=0 → DONE.
  - If transfer and load_req=0 in the same cycle, the transfer wins and the byte is written.
- ADDR: bus_oe=1, bus_out={0,load_addr}, nLma=0 (bit 11), other bits IDLE. → DATA.
- DATA: bus_oe=1, bus_out=byte, nLmd=0 (bit 10). → WRITE.
- WRITE:
  - bus_oe=0, nLr=0 (bit 8), nCE stays 1.
  - If load_addr==RAM_BYTES-1: → DONE, load_addr wraps to 0.
  - Else: load_addr+1 → WAIT.
- DONE (1 cycle):
  - load_done=1, ctrl_out=IDLE, cpu_rst_n=0.
  - → RUN; cpu_rst_n returns to 1 in the first RUN cycle, so the CPU restarts at PC=0.
- Timing: one byte costs 4 cycles minimum (WAIT, ADDR, DATA, WRITE); wr_ready is low in ADDR/DATA/WRITE.
- cpu_rst_n is low in every state except RUN.
- load_req asserted during DONE: the block goes to RUN for one cycle, then HOLD (no re-entry without passing through RUN).
- load_req deasserted during ADDR/DATA/WRITE: the current byte completes; exit is evaluated in WAIT.
- A full 16-byte load exits via DONE regardless of load_req. If load_req is still 1 afterwards, a new load starts from address 0.
- rst_n low in any state: immediate return to reset values. The partial RAM contents are left as-is.
- bus_oe=1 only in ADDR and DATA. The CPU never drives the bus in those states because ctrl_out=IDLE.

Optional Feature:
- Macro LOADER_CHECKSUM_EN.
- Defined:
  - checksum is an 8-bit modulo-256 sum of all bytes written since the last HOLD.
  - Cleared in HOLD, updated in WRITE, held in RUN.
- Undefined: checksum is tied to 8'h00 and no adder is built.

Test Plan:
- Reset: rst_n=0 with load_req=1 → ctrl_out==cpu_ctrl, wr_ready=0, cpu_rst_n=1, load_addr=0.
- Passthrough: in RUN drive cpu_ctrl=15'h5A5A → ctrl_out=15'h5A5A same cycle, bus_oe=0.
- Full load: load_req=1, stream bytes 0x10..0x1F with wr_valid always high:
  - 16 RAM writes to addr 0..15, each preceded by an ADDR and a DATA cycle.
  - load_done pulses once, 64 cycles after the first WAIT.
  - checksum=0x78 with LOADER_CHECKSUM_EN.
  - CPU runs afterwards with PC=0.
- Early exit: load 3 bytes (0xAA, 0xBB, 0xCC), then drop load_req in WAIT → DONE next cycle, load_done=1, load_addr=3 before DONE, RAM[0..2]=AA,BB,CC.
- Simultaneous: wr_valid=1 and load_req falling in the same WAIT cycle → the byte is still written, then DONE.
- Async reset mid-write: rst_n low during DATA → bus_oe=0 and state=RUN immediately, without waiting for a clock edge.
